// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register file write-port arbiter with result FIFO and scoreboard
// ALU writeback has fixed priority; long-latency results queue in a small FIFO.
module regfile_wb_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        aWrite,
  input  logic [4:0]  aRd,
  input  logic [31:0] aData,
  input  logic        bValid,
  input  logic [4:0]  bRd,
  input  logic [31:0] bData,
  output logic        bReady,
  input  logic        issueValid,
  input  logic [4:0]  issueRd,
  input  logic [4:0]  chkRs,
  input  logic [4:0]  chkRt,
  input  logic [4:0]  chkRd,
  output logic        stall,
  output logic        starve,
  output logic        regWrite,
  output logic [4:0]  rd,
  output logic [31:0] dataIn,
  output logic [31:0] busyMask
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [4:0]       fifoRd   [DEPTH];
  logic [31:0]      fifoData [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [CNT_W-1:0] count;
  logic [3:0]       starveCnt;

  logic        aValid;
  logic        fifoEmpty;
  logic        pop;
  logic        push;
  logic        headWrite;
  logic [4:0]  headRd;
  logic [31:0] headData;
  logic [31:0] busyNext;

  assign aValid    = aWrite && (aRd != 5'd0);
  assign fifoEmpty = (count == '0);
  assign headRd    = fifoRd[rdPtr];
  assign headData  = fifoData[rdPtr];

  // Readiness comes from the pre-pop count, so a full FIFO never pushes while popping.
  assign bReady    = (count < CNT_W'(DEPTH));
  assign push      = bValid && bReady;
  assign pop       = !aValid && !fifoEmpty;
  assign headWrite = pop && (headRd != 5'd0);

  assign stall = ((chkRs != 5'd0) && busyMask[chkRs]) ||
                 ((chkRt != 5'd0) && busyMask[chkRt]) ||
                 ((chkRd != 5'd0) && busyMask[chkRd]);

  // Issue is applied after completion so a same-cycle set beats the clear.
  always_comb begin
    busyNext = busyMask;
    if (headWrite) busyNext[headRd] = 1'b0;
    if (issueValid && (issueRd != 5'd0)) busyNext[issueRd] = 1'b1;
    busyNext[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifoRd[wrPtr]   <= bRd;
      fifoData[wrPtr] <= bData;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regWrite <= 1'b0;
      rd       <= 5'd0;
      dataIn   <= 32'd0;
    end else if (aValid) begin
      regWrite <= 1'b1;
      rd       <= aRd;
      dataIn   <= aData;
    end else if (headWrite) begin
      regWrite <= 1'b1;
      rd       <= headRd;
      dataIn   <= headData;
    end else begin
      regWrite <= 1'b0;
    end
  end

  // A non-empty FIFO that does not pop has necessarily lost to a valid A request.
  always_ff @(posedge clk) begin
    if (rst) begin
      starveCnt <= 4'd0;
      starve    <= 1'b0;
    end else if (pop || fifoEmpty) begin
      starveCnt <= 4'd0;
      starve    <= 1'b0;
    end else if (starveCnt == 4'(STARVE_LIMIT - 1)) begin
      starveCnt <= 4'd0;
      starve    <= 1'b1;
    end else begin
      starveCnt <= starveCnt + 4'd1;
      starve    <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) busyMask <= 32'd0;
    else     busyMask <= busyNext;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
  localparam int DEPTH = 2;
  localparam int STARVE_LIMIT = 4;

  logic clk = 1'b0;
  logic rst;
  logic aWrite, bValid, issueValid;
  logic [4:0] aRd, bRd, issueRd, chkRs, chkRt, chkRd;
  logic [31:0] aData, bData;
  logic bReady, stall, starve, regWrite;
  logic [4:0] rd;
  logic [31:0] dataIn, busyMask;

  int total = 0;
  int bad = 0;

  regfile_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .aWrite(aWrite), .aRd(aRd), .aData(aData),
    .bValid(bValid), .bRd(bRd), .bData(bData), .bReady(bReady),
    .issueValid(issueValid), .issueRd(issueRd),
    .chkRs(chkRs), .chkRt(chkRt), .chkRd(chkRd),
    .stall(stall), .starve(starve),
    .regWrite(regWrite), .rd(rd), .dataIn(dataIn), .busyMask(busyMask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] mBusy;
  int          mCnt;
  logic        mRegWrite;
  logic [4:0]  mRd;
  logic [31:0] mData;
  logic        mStarve;

  typedef struct {
    logic        aWrite;
    logic [4:0]  aRd;
    logic [31:0] aData;
    logic        bValid;
    logic [4:0]  bRd;
    logic [31:0] bData;
    logic        issueValid;
    logic [4:0]  issueRd;
    logic [4:0]  chkRs;
    logic        eBReady;
    logic        eStall;
    logic        eRegWrite;
    logic [4:0]  eRd;
    logic [31:0] eData;
    logic        eStarve;
    logic [31:0] eBusy;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic modelStall();
    return (chkRs != 0 && mBusy[chkRs]) || (chkRt != 0 && mBusy[chkRt]) ||
           (chkRd != 0 && mBusy[chkRd]);
  endfunction

  task automatic modelReset();
    mq.delete();
    mBusy = 0;
    mCnt = 0;
    mRegWrite = 0;
    mRd = 0;
    mData = 0;
    mStarve = 0;
  endtask

  task automatic modelEdge();
    ent_t h;
    logic aV, wasEmpty, popNow, pushNow;
    if (rst) begin
      modelReset();
      return;
    end
    aV = aWrite && aRd != 0;
    wasEmpty = (mq.size() == 0);
    popNow = !aV && !wasEmpty;
    pushNow = bValid && (mq.size() < DEPTH);
    if (aV) begin
      mRegWrite = 1; mRd = aRd; mData = aData;
    end else if (popNow) begin
      h = mq.pop_front();
      if (h.rd != 0) begin
        mRegWrite = 1; mRd = h.rd; mData = h.data; mBusy[h.rd] = 0;
      end else begin
        mRegWrite = 0;
      end
    end else begin
      mRegWrite = 0;
    end
    if (popNow || wasEmpty) begin
      mCnt = 0; mStarve = 0;
    end else begin
      mCnt++;
      mStarve = (mCnt == STARVE_LIMIT);
      if (mStarve) mCnt = 0;
    end
    if (issueValid && issueRd != 0) mBusy[issueRd] = 1;
    if (pushNow) mq.push_back('{bRd, bData});
  endtask

  task automatic cycle();
    #1;
    chk("bReady", bReady, mq.size() < DEPTH);
    chk("stall", stall, modelStall());
    if (mStarve) chk("starve_protocol_aWrite", aWrite, 0);
    @(posedge clk);
    modelEdge();
    #1;
    chk("regWrite", regWrite, mRegWrite);
    chk("rd", rd, mRd);
    chk("dataIn", dataIn, mData);
    chk("starve", starve, mStarve);
    chk("busyMask", busyMask, mBusy);
  endtask

  task automatic drive(input logic aw, input logic [4:0] ard, input logic [31:0] ad,
                       input logic bv, input logic [4:0] brd, input logic [31:0] bd,
                       input logic iv, input logic [4:0] ird);
    aWrite = aw; aRd = ard; aData = ad;
    bValid = bv; bRd = brd; bData = bd;
    issueValid = iv; issueRd = ird;
  endtask

  initial begin
    rst = 1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chkRs = 0; chkRt = 0; chkRd = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    modelReset();
    rst = 0;
    chk("reset_regWrite", regWrite, 0);
    chk("reset_rd", rd, 0);
    chk("reset_dataIn", dataIn, 0);
    chk("reset_starve", starve, 0);
    chk("reset_busyMask", busyMask, 0);
    chk("reset_bReady", bReady, 1);
    chk("reset_stall", stall, 0);

    // A write latency, then issue/complete of reg 10 through the FIFO
    vecs[0] = '{1, 9, 32'hA, 0, 0, 0, 0, 0, 0,  1, 0, 1, 9, 32'hA, 0, 32'h0};
    vecs[1] = '{0, 0, 0,     0, 0, 0, 0, 0, 0,  1, 0, 0, 9, 32'hA, 0, 32'h0};
    vecs[2] = '{0, 0, 0,     0, 0, 0, 1, 10, 10, 1, 0, 0, 9, 32'hA, 0, 32'h400};
    vecs[3] = '{0, 0, 0,     0, 0, 0, 0, 0, 10, 1, 1, 0, 9, 32'hA, 0, 32'h400};
    vecs[4] = '{0, 0, 0,     0, 0, 0, 0, 0, 10, 1, 1, 0, 9, 32'hA, 0, 32'h400};
    vecs[5] = '{0, 0, 0,     1, 10, 32'hC, 0, 0, 10, 1, 1, 0, 9, 32'hA, 0, 32'h400};
    vecs[6] = '{0, 0, 0,     0, 0, 0, 0, 0, 10, 1, 1, 1, 10, 32'hC, 0, 32'h0};
    vecs[7] = '{0, 0, 0,     0, 0, 0, 0, 0, 10, 1, 0, 0, 10, 32'hC, 0, 32'h0};
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].aWrite, vecs[i].aRd, vecs[i].aData, vecs[i].bValid, vecs[i].bRd,
            vecs[i].bData, vecs[i].issueValid, vecs[i].issueRd);
      chkRs = vecs[i].chkRs;
      #1;
      chk($sformatf("vec%0d_bReady", i), bReady, vecs[i].eBReady);
      chk($sformatf("vec%0d_stall", i), stall, vecs[i].eStall);
      cycle();
      chk($sformatf("vec%0d_regWrite", i), regWrite, vecs[i].eRegWrite);
      chk($sformatf("vec%0d_rd", i), rd, vecs[i].eRd);
      chk($sformatf("vec%0d_dataIn", i), dataIn, vecs[i].eData);
      chk($sformatf("vec%0d_starve", i), starve, vecs[i].eStarve);
      chk($sformatf("vec%0d_busyMask", i), busyMask, vecs[i].eBusy);
    end
    chkRs = 0;

    // Starvation: one entry for reg 12 denied by a continuous A stream
    drive(1, 11, 32'h11, 1, 12, 32'h12, 0, 0);
    cycle();
    drive(1, 11, 32'h11, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      cycle();
      chk($sformatf("starve_after_%0d", i), starve, (i == 4) ? 1 : 0);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    chk("starve_pop_regWrite", regWrite, 1);
    chk("starve_pop_rd", rd, 12);
    chk("starve_pop_dataIn", dataIn, 32'h12);
    chk("starve_cleared", starve, 0);
    cycle();

    // Full FIFO backpressure and ordering
    drive(1, 11, 32'h11, 1, 13, 32'h21, 0, 0);
    cycle();
    drive(1, 11, 32'h11, 1, 14, 32'h22, 0, 0);
    cycle();
    drive(1, 11, 32'h11, 1, 15, 32'h23, 0, 0);
    #1;
    chk("full_bReady", bReady, 0);
    cycle();
    cycle();
    cycle();
    chk("full_starve", starve, 1);
    drive(0, 0, 0, 1, 15, 32'h23, 0, 0);
    #1;
    chk("full_pop_cycle_bReady", bReady, 0);
    cycle();
    chk("order_first_rd", rd, 13);
    chk("order_first_dataIn", dataIn, 32'h21);
    drive(1, 11, 32'h11, 1, 15, 32'h23, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    chk("order_second_rd", rd, 14);
    cycle();
    chk("order_third_rd", rd, 15);
    chk("order_third_dataIn", dataIn, 32'h23);
    cycle();

    // Register 0 from either side never writes
    drive(1, 0, 32'h99, 1, 0, 32'h55, 0, 0);
    cycle();
    chk("r0_a_regWrite", regWrite, 0);
    chk("r0_a_rd_hold", rd, 15);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    chk("r0_pop_regWrite", regWrite, 0);
    chk("r0_pop_dataIn_hold", dataIn, 32'h23);
    #1;
    chk("r0_fifo_drained_bReady", bReady, 1);

    // Same-cycle issue and completion of reg 11: the set wins
    drive(0, 0, 0, 0, 0, 0, 1, 11);
    cycle();
    drive(0, 0, 0, 1, 11, 32'h77, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 1, 11);
    cycle();
    chk("setwins_regWrite", regWrite, 1);
    chk("setwins_rd", rd, 11);
    chk("setwins_busy11", busyMask[11], 1);

    // Reset mid-operation
    drive(1, 3, 32'h33, 1, 5, 32'h55, 1, 6);
    cycle();
    rst = 1;
    cycle();
    rst = 0;
    chk("midrst_regWrite", regWrite, 0);
    chk("midrst_rd", rd, 0);
    chk("midrst_dataIn", dataIn, 0);
    chk("midrst_busyMask", busyMask, 0);
    chk("midrst_starve", starve, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cycle();

    // Randomized traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 249) == 0);
      aWrite = mStarve ? 1'b0 : ($urandom_range(0, 2) != 0);
      aRd = 5'($urandom_range(0, 7));
      aData = $urandom;
      bValid = $urandom_range(0, 1);
      bRd = 5'($urandom_range(0, 7));
      bData = $urandom;
      issueValid = ($urandom_range(0, 3) == 0);
      issueRd = 5'($urandom_range(0, 7));
      chkRs = 5'($urandom_range(0, 7));
      chkRt = 5'($urandom_range(0, 7));
      chkRd = 5'($urandom_range(0, 7));
      cycle();
    end
    rst = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
